// File: rtl/seq_detector_prog_if.sv
// Bus bundle for the programmable sequence detector:
// serial input, runtime configuration and match outputs.
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               din_valid;
    logic               din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               detect;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport master (
        output din_valid, din, cfg_load,
        output cfg_pattern, cfg_len, cfg_overlap,
        input  detect, match_count, cfg_err
    );

    modport slave (
        input  din_valid, din, cfg_load,
        input  cfg_pattern, cfg_len, cfg_overlap,
        output detect, match_count, cfg_err
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial sequence detector with
// overlap select, one-cycle detect pulse and saturating count.
module seq_detector_prog #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    seq_detector_prog_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(4);
    localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(4'b1000);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_n;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic               match;
    logic               cfg_ok;
    logic               detect_q;
    logic               cfg_err_q;
    logic [CNT_W-1:0]   cnt_q;

    assign bus.detect      = detect_q;
    assign bus.match_count = cnt_q;
    assign bus.cfg_err     = cfg_err_q;

    // Next history/fill and the masked compare of the newest len bits
    always_comb begin
        hist_n = {hist[MAX_LEN-2:0], bus.din};
        fill_n = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
        mask   = ~({MAX_LEN{1'b1}} << len);
        match  = (fill_n >= len) && (((hist_n ^ pat) & mask) == '0);
        cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);
    end

    // Config load beats data; a match in non-overlap mode empties fill
    always_ff @(posedge clk) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            pat       <= PAT_RST;
            len       <= LEN_RST;
            ovl       <= 1'b1;
            detect_q  <= 1'b0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else if (bus.cfg_load) begin
            detect_q <= 1'b0;
            if (cfg_ok) begin
                pat       <= bus.cfg_pattern;
                len       <= bus.cfg_len;
                ovl       <= bus.cfg_overlap;
                fill      <= '0;
                cnt_q     <= '0;
                cfg_err_q <= 1'b0;
            end else begin
                cfg_err_q <= 1'b1;
            end
        end else if (bus.din_valid) begin
            hist     <= hist_n;
            detect_q <= match;
            if (match) begin
                if (cnt_q != '1)
                    cnt_q <= cnt_q + CNT_W'(1);
                fill <= ovl ? fill_n : '0;
            end else begin
                fill <= fill_n;
            end
        end else begin
            detect_q <= 1'b0;
        end
    end
endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Runtime-programmable serial sequence detector, the parametrised successor to the fixed "1000" Moore detector in the sequence-detector set. It samples one bit per qualified cycle and compares the most recent `cfg_len` bits (1..MAX_LEN) against a loaded pattern. Overlapping or non-overlapping matching is selected at runtime. It produces a registered one-cycle `detect` pulse per match and keeps a saturating match counter. It sits directly on a serial bit stream, ahead of any framing or alarm logic.

## Interface
- `MAX_LEN`, 16: maximum pattern length in bits; legal range 4..64.
- `CNT_W`, 8: width of `match_count`; minimum 1.
- `clk`  in  1  single clock; all logic is clocked on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din_valid`  in  1  `din` is sampled only in cycles where this is high.
- `din`  in  1  serial data bit.
- `cfg_load`  in  1  loads the configuration on this cycle.
- `cfg_pattern`  in  MAX_LEN  pattern bits. Bit `cfg_len-1` is the first bit received; bit 0 is the last. Bits at `cfg_len` and above are ignored.
- `cfg_len`  in  $clog2(MAX_LEN+1)  pattern length.
- `cfg_overlap`  in  1  1 = overlapping detection; 0 = non-overlapping.
- `detect`  out  1  registered match pulse.
- `match_count`  out  CNT_W  saturating count of matches.
- `cfg_err`  out  1  set when a load is rejected.

## Operation
- Internal state:
  - `hist[MAX_LEN-1:0]`: bit history, newest bit in `hist[0]`.
  - `fill`: number of valid history bits, 0..MAX_LEN.
  - Latched `pat`, `len` and `ovl`.
- Reset values:
  - `pat = 'b1000` (zero-extended), `len = 4`, `ovl = 1`.
  - `hist = 0`, `fill = 0`.
  - `detect = 0`, `match_count = 0`, `cfg_err = 0`.
- Accept cycle (`din_valid=1`, `cfg_load=0`):
  - `hist_n = {hist[MAX_LEN-2:0], din}`.
  - `fill_n = min(fill+1, MAX_LEN)`.
  - `match = (fill_n >= len) && (hist_n[len-1:0] == pat[len-1:0])`.
  - On a match:
    - `detect <= 1`.
    - `match_count` increments, holding at all-ones once saturated.
    - If `ovl=0`, `fill <= 0`. The history bits are kept, but they cannot contribute to a later match until they are refilled.
  - With no match, `detect <= 0`.
- Idle cycle (`din_valid=0`, `cfg_load=0`): `detect <= 0`; all other state holds.
- Load cycle (`cfg_load=1`):
  - Takes priority over `din_valid`; a `din` bit presented in the same cycle is discarded.
  - Valid load (`1 <= cfg_len <= MAX_LEN`):
    - Latch `pat`, `len` and `ovl`.
    - `fill <= 0`, `detect <= 0`, `match_count <= 0`, `cfg_err <= 0`.
  - Rejected load (`cfg_len == 0` or `cfg_len > MAX_LEN`):
    - Configuration, `hist`, `fill` and `match_count` are unchanged.
    - `cfg_err <= 1`, `detect <= 0`.
- `cfg_err` is sticky. It clears only on reset or on a valid load.
- `rst` overrides everything in the same edge, including in the middle of a pattern; a partial match is lost.

## Timing
- Detect latency: `detect` is high in the cycle after the clock edge that samples the completing bit, and stays high for exactly one cycle.
- `match_count` updates on the same edge as `detect` rises.
- With continuous `din_valid` in overlap mode, back-to-back matches give consecutive `detect` cycles. Example: pattern `11`, input `111` gives detect after bit 2 and after bit 3.
- Gaps in `din_valid` do not break a partial match; only qualified bits count.
- A new configuration applies to the first qualified bit after the load edge. A match needs `len` fresh bits after the load.
- The match compare is a single-cycle combinational equality on at most MAX_LEN bits; there is no pipelining.

## Test plan
- Reset default:
  - Stimulus: after reset, `din` = 1,0,0,0 with `din_valid` every cycle.
  - Required: `detect` is 1 for exactly one cycle, one cycle after bit 4; `match_count=1`.
- Overlap vs non-overlap:
  - Stimulus: load `cfg_pattern='b101`, `cfg_len=3`, then stream 1,0,1,0,1.
  - Required with `cfg_overlap=1`: detect after bits 3 and 5, count 2.
  - Required with `cfg_overlap=0`: detect after bit 3 only, count 1.
- Valid gaps:
  - Stimulus: default config; send 1,0,0,0 with `din_valid` low on alternate cycles.
  - Required: one detect pulse, one cycle after the 4th qualified bit; no pulse during idle cycles.
- Rejected load:
  - Stimulus: `cfg_load` with `cfg_len=0`, then with `cfg_len=MAX_LEN+1`.
  - Required: `cfg_err=1` and stays set. The default `1000` still detects with the count continuing, and `fill` is unaffected. A subsequent valid load clears `cfg_err`.
- Load/valid collision and saturation:
  - Stimulus: `cfg_load` and `din_valid` high in the same cycle.
  - Required: that bit is dropped, `match_count=0`, and the pattern needs `len` new bits to match.
  - Stimulus: with `CNT_W=2`, five matches.
  - Required: `match_count` holds at 3.
- Mid-sequence reset:
  - Stimulus: send 1,0,0, assert `rst` for one cycle, then send 0.
  - Required: no `detect` pulse; all outputs are 0 in the cycle after reset.
